// File: rtl/game_sequencer.sv
// game_sequencer: frame-paced game-flow controller for the Asteroids top level.
// Sequences title zoom, get-ready pause, play, respawn, level-clear and game-over.
// All timing is counted in frames using the one-cycle vsync pulse.
// Optional feature macro: GAME_SEQ_AUTO_RESTART_EN. When it is defined, the game
// returns from OVER to INTRO on its own after 600 frames (attract loop).
// Every output is registered. Each output is computed from the next-state values,
// so it is valid in the first cycle the machine spends in the new state.
module game_sequencer #(
  parameter int INTRO_FRAMES   = 256,
  parameter int READY_FRAMES   = 256,
  parameter int RESPAWN_FRAMES = 90,
  parameter int INVULN_FRAMES  = 120,
  parameter int CLEAR_FRAMES   = 60,
  parameter int LEVEL_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_pulse,
  input  logic               die,
  input  logic               lives_zero,
  input  logic               field_clear,
  input  logic               restart,
  output logic [7:0]         intro_scale,
  output logic               start_done,
  output logic               game_begin,
  output logic               new_level,
  output logic [LEVEL_W-1:0] level,
  output logic               ship_show,
  output logic               invuln,
  output logic               game_over
);

  // Frames spent in OVER before the attract loop restarts the title.
  localparam int AUTO_FRAMES = 600;

  localparam int MAX_AB = (INTRO_FRAMES > READY_FRAMES) ? INTRO_FRAMES : READY_FRAMES;
  localparam int MAX_CD = (RESPAWN_FRAMES > CLEAR_FRAMES) ? RESPAWN_FRAMES : CLEAR_FRAMES;
  localparam int MAX_BASE = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
`ifdef GAME_SEQ_AUTO_RESTART_EN
  localparam int MAX_FRAMES = (MAX_BASE > AUTO_FRAMES) ? MAX_BASE : AUTO_FRAMES;
`else
  localparam int MAX_FRAMES = MAX_BASE;
`endif
  localparam int CNT_W = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   INTRO_LAST   = CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0]   READY_LAST   = CNT_W'(READY_FRAMES - 1);
  localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CLEAR_LAST   = CNT_W'(CLEAR_FRAMES - 1);
`ifdef GAME_SEQ_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0]   AUTO_LAST    = CNT_W'(AUTO_FRAMES - 1);
`endif
  localparam logic [INV_W-1:0]   INV_ZERO     = {INV_W{1'b0}};
  localparam logic [INV_W-1:0]   INV_ONE      = INV_W'(1);
  localparam logic [INV_W-1:0]   INV_LOAD     = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0]   INV_BLINK    = INV_W'(8);
  localparam logic [LEVEL_W-1:0] LEVEL_ZERO   = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LEVEL_ONE    = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX    = {LEVEL_W{1'b1}};

  typedef enum logic [2:0] {
    S_INTRO   = 3'd0,
    S_READY   = 3'd1,
    S_PLAY    = 3'd2,
    S_RESPAWN = 3'd3,
    S_CLEAR   = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [INV_W-1:0]   inv_cnt, inv_next;
  logic [LEVEL_W-1:0] level_next;
  logic               new_level_next;
  logic               restart_d;
  logic               restart_edge;
  logic [INV_W-1:0]   inv_elapsed;

  logic [7:0]         intro_scale_next;
  logic               start_done_next;
  logic               game_begin_next;
  logic               ship_show_next;
  logic               invuln_next;
  logic               game_over_next;

  assign restart_edge = restart & ~restart_d;

  // Restart history; sampled even during reset so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    restart_d <= restart;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INTRO;
      cnt     <= CNT_ZERO;
      inv_cnt <= INV_ZERO;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      inv_cnt <= inv_next;
    end
  end

  // Next-state, frame counter, invulnerability counter and level update.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    level_next     = level;
    new_level_next = 1'b0;
    // Invulnerability runs down once per frame while the ship is on screen.
    if (((state == S_PLAY) || (state == S_CLEAR)) && vsync_pulse && (inv_cnt != INV_ZERO)) begin
      inv_next = inv_cnt - INV_ONE;
    end else begin
      inv_next = inv_cnt;
    end
    case (state)
      S_INTRO: begin
        inv_next = INV_ZERO;
        if (vsync_pulse) begin
          if (cnt == INTRO_LAST) begin
            state_next = S_READY;
            cnt_next   = CNT_ZERO;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      S_READY: begin
        if (vsync_pulse) begin
          if (cnt == READY_LAST) begin
            state_next     = S_PLAY;
            cnt_next       = CNT_ZERO;
            level_next     = LEVEL_ONE;
            new_level_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      S_PLAY: begin
        // A death outranks a cleared field arriving in the same cycle.
        if (die && (inv_cnt == INV_ZERO)) begin
          state_next = S_RESPAWN;
          cnt_next   = CNT_ZERO;
          inv_next   = INV_ZERO;
        end else if (field_clear) begin
          state_next = S_CLEAR;
          cnt_next   = CNT_ZERO;
        end else begin
          state_next = S_PLAY;
        end
      end
      S_RESPAWN: begin
        inv_next = INV_ZERO;
        if (vsync_pulse) begin
          if (cnt == RESPAWN_LAST) begin
            cnt_next = CNT_ZERO;
            if (lives_zero) begin
              state_next = S_OVER;
            end else begin
              state_next = S_PLAY;
              inv_next   = INV_LOAD;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      S_CLEAR: begin
        if (vsync_pulse) begin
          if (cnt == CLEAR_LAST) begin
            state_next     = S_PLAY;
            cnt_next       = CNT_ZERO;
            new_level_next = 1'b1;
            if (level != LEVEL_MAX) begin
              level_next = level + LEVEL_ONE;
            end else begin
              level_next = LEVEL_MAX;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end else begin
          cnt_next = cnt;
        end
      end
      S_OVER: begin
        inv_next = INV_ZERO;
        if (restart_edge) begin
          state_next = S_INTRO;
          cnt_next   = CNT_ZERO;
          level_next = LEVEL_ZERO;
`ifdef GAME_SEQ_AUTO_RESTART_EN
        end else if (vsync_pulse) begin
          if (cnt == AUTO_LAST) begin
            state_next = S_INTRO;
            cnt_next   = CNT_ZERO;
            level_next = LEVEL_ZERO;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
`endif
        end else begin
          cnt_next = cnt;
        end
      end
      default: begin
        state_next = S_INTRO;
        cnt_next   = CNT_ZERO;
        inv_next   = INV_ZERO;
        level_next = LEVEL_ZERO;
      end
    endcase
  end

  // Frames elapsed since the respawn; bit 3 gives the 16-frame blink period.
  assign inv_elapsed = INV_LOAD - inv_next;

  // Output decode from the next state so registered outputs line up with the state.
  always_comb begin
    if (state_next == S_INTRO) begin
      intro_scale_next = 8'(cnt_next);
    end else begin
      intro_scale_next = 8'd0;
    end
    start_done_next = (state_next != S_INTRO);
    game_begin_next = (state_next == S_PLAY) || (state_next == S_RESPAWN) ||
                      (state_next == S_CLEAR);
    invuln_next     = (inv_next != INV_ZERO);
    if ((state_next == S_PLAY) || (state_next == S_CLEAR)) begin
      ship_show_next = (inv_next == INV_ZERO) || ((inv_elapsed & INV_BLINK) == INV_ZERO);
    end else begin
      ship_show_next = 1'b0;
    end
    game_over_next  = (state_next == S_OVER);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      intro_scale <= 8'd0;
      start_done  <= 1'b0;
      game_begin  <= 1'b0;
      new_level   <= 1'b0;
      level       <= LEVEL_ZERO;
      ship_show   <= 1'b0;
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      intro_scale <= intro_scale_next;
      start_done  <= start_done_next;
      game_begin  <= game_begin_next;
      new_level   <= new_level_next;
      level       <= level_next;
      ship_show   <= ship_show_next;
      invuln      <= invuln_next;
      game_over   <= game_over_next;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed vector table, hand sequences for the
// multi-cycle corners, and random stimulus checked every cycle against a
// frame-countdown reference model.
module tb_game_sequencer;
  localparam int INTRO_F = 256;
  localparam int READY_F = 256;
  localparam int RESP_F  = 90;
  localparam int INV_F   = 120;
  localparam int CLEAR_F = 60;
  localparam int LW      = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, vsync_pulse, die, lives_zero, field_clear, restart;
  logic [7:0] intro_scale;
  logic start_done, game_begin, new_level;
  logic [LW-1:0] level;
  logic ship_show, invuln, game_over;

  game_sequencer #(
    .INTRO_FRAMES(INTRO_F), .READY_FRAMES(READY_F), .RESPAWN_FRAMES(RESP_F),
    .INVULN_FRAMES(INV_F), .CLEAR_FRAMES(CLEAR_F), .LEVEL_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .vsync_pulse(vsync_pulse), .die(die),
    .lives_zero(lives_zero), .field_clear(field_clear), .restart(restart),
    .intro_scale(intro_scale), .start_done(start_done), .game_begin(game_begin),
    .new_level(new_level), .level(level), .ship_show(ship_show),
    .invuln(invuln), .game_over(game_over)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase plus frames remaining in it.
  typedef enum {P_INTRO, P_READY, P_PLAY, P_RESPAWN, P_CLEAR, P_OVER} phase_t;
  phase_t m_ph;
  int m_left, m_inv_left, m_since, m_level;
  bit m_nl, m_rs_prev;

  function automatic logic [17:0] mk(int isc, int sd, int gb, int nl, int lvl,
                                     int ss, int inv, int go);
    return {8'(isc), 1'(sd), 1'(gb), 1'(nl), 4'(lvl), 1'(ss), 1'(inv), 1'(go)};
  endfunction

  function logic [17:0] dut_vec();
    return {intro_scale, start_done, game_begin, new_level, level, ship_show, invuln, game_over};
  endfunction

  function logic [17:0] model_vec();
    int isc;
    int show;
    isc  = (m_ph == P_INTRO) ? ((INTRO_F - m_left) % 256) : 0;
    show = ((m_ph == P_PLAY) || (m_ph == P_CLEAR)) &&
           ((m_inv_left == 0) || (((m_since / 8) % 2) == 0));
    return mk(isc, m_ph != P_INTRO,
              (m_ph == P_PLAY) || (m_ph == P_RESPAWN) || (m_ph == P_CLEAR),
              m_nl, m_level, show, m_inv_left != 0, m_ph == P_OVER);
  endfunction

  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (isc,sd,gb,nl,lvl,ss,inv,go)", name, act, exp);
  endtask

  task automatic model_step(bit r, bit v, bit d, bit fc, bit lz, bit rs);
    bit edge_seen;
    bit was_invuln;
    if (r) begin
      m_ph = P_INTRO; m_left = INTRO_F; m_inv_left = 0; m_since = 0;
      m_level = 0; m_nl = 0; m_rs_prev = rs;
    end else begin
      edge_seen  = rs && !m_rs_prev;
      m_rs_prev  = rs;
      m_nl       = 0;
      was_invuln = (m_inv_left != 0);
      if ((m_ph == P_PLAY || m_ph == P_CLEAR) && v && m_inv_left > 0) begin
        m_inv_left--; m_since++;
      end
      case (m_ph)
        P_INTRO: if (v) begin
          m_left--;
          if (m_left == 0) begin m_ph = P_READY; m_left = READY_F; end
        end
        P_READY: if (v) begin
          m_left--;
          if (m_left == 0) begin m_ph = P_PLAY; m_level = 1; m_nl = 1; end
        end
        P_PLAY: begin
          if (d && !was_invuln) begin
            m_ph = P_RESPAWN; m_left = RESP_F; m_inv_left = 0;
          end else if (fc) begin
            m_ph = P_CLEAR; m_left = CLEAR_F;
          end
        end
        P_RESPAWN: if (v) begin
          m_left--;
          if (m_left == 0) begin
            if (lz) begin m_ph = P_OVER; m_left = 600; end
            else begin m_ph = P_PLAY; m_inv_left = INV_F; m_since = 0; end
          end
        end
        P_CLEAR: if (v) begin
          m_left--;
          if (m_left == 0) begin
            m_ph = P_PLAY; m_nl = 1;
            if (m_level < (1 << LW) - 1) m_level++;
          end
        end
        P_OVER: begin
          if (edge_seen) begin
            m_ph = P_INTRO; m_left = INTRO_F; m_level = 0;
          end
`ifdef GAME_SEQ_AUTO_RESTART_EN
          else if (v) begin
            m_left--;
            if (m_left == 0) begin m_ph = P_INTRO; m_left = INTRO_F; m_level = 0; end
          end
`endif
        end
        default: m_ph = P_INTRO;
      endcase
    end
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic tick(bit r, bit v, bit d, bit fc, bit lz, bit rs);
    rst = r; vsync_pulse = v; die = d; field_clear = fc; lives_zero = lz; restart = rs;
    model_step(r, v, d, fc, lz, rs);
    @(posedge clk);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic ticks(int n, bit v, bit d, bit fc, bit lz, bit rs);
    for (int k = 0; k < n; k++) tick(1'b0, v, d, fc, lz, rs);
  endtask

  typedef struct {
    int n;
    bit v;
    bit d;
    bit fc;
    logic [17:0] exp;
  } vec_t;
  vec_t tbl[21];

  initial begin
    bit rs_lvl;
    rst = 1'b1; vsync_pulse = 1'b0; die = 1'b0; lives_zero = 1'b0;
    field_clear = 1'b0; restart = 1'b0;

    //                n    v  d  fc   isc sd gb nl lvl ss inv go
    tbl[0]  = '{1,   0, 0, 0, mk(0,   0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{100, 1, 0, 0, mk(100, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{155, 1, 0, 0, mk(255, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1,   1, 0, 0, mk(0,   1, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{255, 1, 0, 0, mk(0,   1, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1,   1, 0, 0, mk(0,   1, 1, 1, 1, 1, 0, 0)};
    tbl[6]  = '{1,   0, 0, 0, mk(0,   1, 1, 0, 1, 1, 0, 0)};
    tbl[7]  = '{1,   0, 1, 0, mk(0,   1, 1, 0, 1, 0, 0, 0)};
    tbl[8]  = '{89,  1, 0, 0, mk(0,   1, 1, 0, 1, 0, 0, 0)};
    tbl[9]  = '{1,   1, 0, 0, mk(0,   1, 1, 0, 1, 1, 1, 0)};
    tbl[10] = '{8,   1, 0, 0, mk(0,   1, 1, 0, 1, 0, 1, 0)};
    tbl[11] = '{1,   0, 1, 0, mk(0,   1, 1, 0, 1, 0, 1, 0)};
    tbl[12] = '{8,   1, 0, 0, mk(0,   1, 1, 0, 1, 1, 1, 0)};
    tbl[13] = '{103, 1, 0, 0, mk(0,   1, 1, 0, 1, 1, 1, 0)};
    tbl[14] = '{1,   1, 0, 0, mk(0,   1, 1, 0, 1, 1, 0, 0)};
    tbl[15] = '{1,   0, 1, 1, mk(0,   1, 1, 0, 1, 0, 0, 0)};
    tbl[16] = '{90,  1, 0, 1, mk(0,   1, 1, 0, 1, 1, 1, 0)};
    tbl[17] = '{1,   0, 0, 1, mk(0,   1, 1, 0, 1, 1, 1, 0)};
    tbl[18] = '{59,  1, 0, 0, mk(0,   1, 1, 0, 1, 0, 1, 0)};
    tbl[19] = '{1,   1, 0, 0, mk(0,   1, 1, 1, 2, 0, 1, 0)};
    tbl[20] = '{1,   0, 0, 0, mk(0,   1, 1, 0, 2, 0, 1, 0)};

    // Reset state.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Directed walk: intro, ready, play, respawn with blink, die vs clear, clear.
    for (int i = 0; i < 21; i++) begin
      ticks(tbl[i].n, tbl[i].v, tbl[i].d, tbl[i].fc, 1'b0, 1'b0);
      check($sformatf("step%0d", i), dut_vec(), tbl[i].exp);
    end

    // Level saturation: clear the field repeatedly, level tops out at 15.
    for (int i = 0; i < 14; i++) begin
      ticks(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      ticks(CLEAR_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("sat%0d", i), {new_level, level}, {1'b1, 4'((i + 3 > 15) ? 15 : i + 3)});
    end

    // Death with no lives left: game over, then restart edge.
    ticks(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(RESP_F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("over", dut_vec(), mk(0, 1, 0, 0, 15, 0, 0, 1));
    ticks(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("restart", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    ticks(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_held", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Back to OVER, then observe the attract-loop behaviour.
    ticks(INTRO_F + READY_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(RESP_F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("over2", dut_vec(), mk(0, 1, 0, 0, 1, 0, 0, 1));
    ticks(599, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("over_599", dut_vec(), mk(0, 1, 0, 0, 1, 0, 0, 1));
`ifdef GAME_SEQ_AUTO_RESTART_EN
    ticks(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("auto_restart", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
`else
    ticks(1401, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("over_2000", dut_vec(), mk(0, 1, 0, 0, 1, 0, 0, 1));
    ticks(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("restart2", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
`endif

    // Random stimulus against the model, including occasional mid-game resets.
    rs_lvl = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 59) == 0) rs_lvl = ~rs_lvl;
      tick($urandom_range(0, 4999) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) == 0, rs_lvl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-paced game-flow controller for the Asteroids top level. It replaces the ad-hoc opening-screen counter with a single state machine: title zoom, get-ready pause, play, respawn, level-clear and game-over. Its outputs feed the title/game-over sprite draw masks, `Asteroid_quad` (`game_begin`, `new_level`), `Ship_unit` (draw mask, collision gating) and the lives/score logic. All timing is counted in frames using the existing one-cycle vsync pulse on `clk_25`.

## Interface
- `INTRO_FRAMES`, default 256: title zoom length; the intro counter runs 0..INTRO_FRAMES-1.
- `READY_FRAMES`, default 256: pause between the end of the title and the first wave.
- `RESPAWN_FRAMES`, default 90: ship-hidden time after a death.
- `INVULN_FRAMES`, default 120: collision-immune time after a respawn.
- `CLEAR_FRAMES`, default 60: pause between clearing the field and spawning the next wave.
- `LEVEL_W`, default 4: width of the level counter.

Ports:
- `clk` in 1: `clk_25`.
- `rst` in 1: synchronous, active-high.
- `vsync_pulse` in 1: one-cycle pulse per frame.
- `die` in 1: ship/asteroid collision, level-sensitive.
- `lives_zero` in 1: the lives counter has reached 0.
- `field_clear` in 1: no asteroid currently enabled.
- `restart` in 1: raw button level, already debounced.
- `intro_scale` out 8: title zoom factor, driven to the title sprite's cos input.
- `start_done` out 1: title finished.
- `game_begin` out 1: gameplay active.
- `new_level` out 1: one-cycle spawn-wave pulse.
- `level` out LEVEL_W: current wave number, starting at 1.
- `ship_show` out 1: ship draw mask.
- `invuln` out 1: collisions are ignored while high.
- `game_over` out 1: game-over banner mask.

## Operation
States:
- **INTRO**: counts frames. `intro_scale` = count[7:0]. On the vsync in which count == INTRO_FRAMES-1, go to READY.
- **READY**: counts READY_FRAMES. When done, go to PLAY with `level` = 1 and pulse `new_level`.
- **PLAY**:
  - `die` && !`invuln` → RESPAWN.
  - else `field_clear` → CLEAR.
  - `die` wins if both are high in the same cycle. `die` is ignored in every other state.
- **RESPAWN**: `ship_show` = 0, counts RESPAWN_FRAMES. At expiry:
  - `lives_zero` → OVER.
  - else → PLAY with the invuln counter loaded to INVULN_FRAMES.
  - `field_clear` is not acted on in RESPAWN. If the field is clear on return to PLAY, PLAY then moves to CLEAR.
- **CLEAR**: counts CLEAR_FRAMES, then → PLAY. `level` is incremented and saturates at 2^LEVEL_W-1. Pulse `new_level`.
- **OVER**: `game_over` = 1, `ship_show` = 0, `game_begin` = 0. A rising edge of `restart` → INTRO, with the frame counter cleared and `level` = 0.

Outputs by state:
- `start_done` = 1 in every state except INTRO.
- `game_begin` = 1 in PLAY, RESPAWN and CLEAR.
- `ship_show` = 1 in PLAY and CLEAR only. While `invuln`, `ship_show` toggles every 8 frames (blink). `invuln` itself stays high.
- `invuln` = 1 while the invuln counter is non-zero. The counter decrements on each vsync in PLAY or CLEAR. It is cleared on entry to RESPAWN, OVER or INTRO.

Counters:
- One shared frame counter, cleared on every state transition, width $clog2 of the largest *_FRAMES.
- The invuln counter is separate.

## Timing
- All outputs are registered.
- Reset values: state INTRO, counters 0. `intro_scale`=0, `start_done`=0, `game_begin`=0, `new_level`=0, `level`=0, `ship_show`=0, `invuln`=0, `game_over`=0.
- Frame-timed transitions take effect on the `vsync_pulse` cycle. Outputs reflect the new state one cycle later.
- `die` transition: the state changes on the cycle after `die` is sampled high, with no vsync wait.
- `new_level` is high for exactly one cycle: the cycle after the vsync that enters PLAY from READY or CLEAR. `level` is already updated in that same cycle.
- `restart` edge detect uses one register stage. The transition to INTRO happens on the cycle after the edge. A `restart` held through reset does not trigger a restart.
- `rst` mid-game returns to INTRO at the next edge, regardless of state.

## Configuration
- `GAME_SEQ_AUTO_RESTART_EN`:
  - Defined: in OVER, after 600 frames without a `restart` edge, go to INTRO automatically (attract loop). A `restart` edge still restarts immediately.
  - Undefined: OVER persists until a `restart` edge.

## Test plan
- Reset, then 256 vsyncs → `start_done` rises; `intro_scale` reads 0..255 across the intro. After 256 more vsyncs → `game_begin`=1, `level`=1, `new_level` high for one cycle.
- In PLAY, `die` for 1 cycle → `ship_show`=0 next cycle. After 90 vsyncs with `lives_zero`=0 → `ship_show` blinks with period 16 frames; `invuln`=1 for 120 vsyncs. A `die` during `invuln` causes no state change.
- In PLAY, `die` and `field_clear` in the same cycle → RESPAWN, not CLEAR; `level` unchanged.
- `field_clear` in PLAY → after 60 vsyncs, `level` 1→2 and one `new_level` pulse. Force `level`=15 and repeat → `level` stays 15.
- RESPAWN expiry with `lives_zero`=1 → `game_over`=1, `game_begin`=0. `restart` rises → INTRO next cycle, `level`=0, `start_done`=0.
- With `GAME_SEQ_AUTO_RESTART_EN` defined: in OVER, no `restart` for 600 vsyncs → INTRO. Without the macro: 2000 vsyncs → still OVER.
